// File: rtl/reg_bank_param_if.sv
// Operand-fetch bus for reg_bank_param: write port, two read ports, forwarding
// inputs and operand outputs. master drives requests, slave is the register bank.
interface reg_bank_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra_a;
  logic [ADDR_W-1:0] ra_b;
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] ans_dm;
  logic [DATA_W-1:0] ans_wb;
  logic [DATA_W-1:0] imm;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              imm_sel;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              ready;

  modport master (
    output we, wa, wd, ra_a, ra_b, ans_ex, ans_dm, ans_wb, imm, sel_a, sel_b, imm_sel,
    input  a, b, ready
  );

  modport slave (
    input  we, wa, wd, ra_a, ra_b, ans_ex, ans_dm, ans_wb, imm, sel_a, sel_b, imm_sel,
    output a, b, ready
  );
endinterface

// File: rtl/reg_bank_param.sv
// Register bank with zeroing sweep after reset, registered write-first reads and operand forwarding.
// Optional macro REG_BANK_ZERO_REG_EN makes register 0 a hard-wired zero.
module reg_bank_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  reg_bank_param_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_a_d  = '0;
    rd_b_d  = '0;
    mem_d   = mem_q;
    wr_en   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        else                             cnt_d   = cnt_q + ADDR_W'(1);
      end
      RUN: begin
        wr_en = bus.we;
`ifdef REG_BANK_ZERO_REG_EN
        if (bus.wa == '0) wr_en = 1'b0;
`endif
        // Write-first: a read of the address being written sees the new data.
        rd_a_d = (wr_en && (bus.ra_a == bus.wa)) ? bus.wd : mem_q[bus.ra_a];
        rd_b_d = (wr_en && (bus.ra_b == bus.wa)) ? bus.wd : mem_q[bus.ra_b];
`ifdef REG_BANK_ZERO_REG_EN
        if (bus.ra_a == '0) rd_a_d = '0;
        if (bus.ra_b == '0) rd_b_d = '0;
`endif
        if (wr_en) mem_d[bus.wa] = bus.wd;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  // Storage has no reset of its own; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  always_comb begin
    bus.ready = (state_q == RUN);
    unique case (bus.sel_a)
      2'b00:   bus.a = rd_a_q;
      2'b01:   bus.a = bus.ans_ex;
      2'b10:   bus.a = bus.ans_dm;
      default: bus.a = bus.ans_wb;
    endcase
    if (bus.imm_sel) bus.b = bus.imm;
    else begin
      unique case (bus.sel_b)
        2'b00:   bus.b = rd_b_q;
        2'b01:   bus.b = bus.ans_ex;
        2'b10:   bus.b = bus.ans_dm;
        default: bus.b = bus.ans_wb;
      endcase
    end
  end
endmodule

// File: doc/reg_bank_param.md
REG_BANK_PARAM -- requirements
Module: reg_bank_param

Interface
REQ-001 Parameter DATA_W, default 16, data width of every register, operand and forwarding input.
REQ-002 Parameter ADDR_W, default 5, register address width; depth DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 we  input  1  write enable.
REQ-006 wa  input  ADDR_W  write address.
REQ-007 wd  input  DATA_W  write data.
REQ-008 ra_a, ra_b  input  ADDR_W  read addresses, port A and port B.
REQ-009 ans_ex, ans_dm, ans_wb  input  DATA_W  forwarded results from the EX, DM and WB stages.
REQ-010 imm  input  DATA_W  immediate operand.
REQ-011 sel_a, sel_b  input  2  forwarding select: 00 register, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-012 imm_sel  input  1  when 1, b = imm, overriding sel_b.
REQ-013 a, b  output  DATA_W  operand outputs.
REQ-014 ready  output  1  1 = clear sweep done; writes accepted.

Function
REQ-015 The FSM SHALL have exactly two states: CLEAR (ready=0) and RUN (ready=1).
REQ-016 In CLEAR, an ADDR_W-bit sweep counter starting at 0 SHALL write zero to register[cnt] each cycle and increment by 1.
REQ-017 CLEAR SHALL go to RUN on the cycle that clears address DEPTH-1, so ready rises exactly DEPTH cycles after rst deasserts.
REQ-018 In CLEAR, we SHALL be ignored and both read registers SHALL load 0.
REQ-019 In RUN, when we=1, register[wa] SHALL take wd at the clock edge.
REQ-020 Reads SHALL be registered: read registers rd_a/rd_b SHALL load register[ra_a]/register[ra_b] at each edge, giving 1-cycle latency.
REQ-021 Read-during-write is write-first: when we=1 in RUN and ra_x==wa, rd_x SHALL load wd, not the old contents.
REQ-022 Simultaneous reads of the same address on A and B SHALL both return the same value.
REQ-023 a SHALL be combinational: sel_a 00 -> rd_a, 01 -> ans_ex, 10 -> ans_dm, 11 -> ans_wb.
REQ-024 b SHALL be imm when imm_sel=1; otherwise it is selected from rd_b by sel_b, using the same mapping as REQ-023.
REQ-025 Forwarding inputs SHALL never be written into the array; only we/wa/wd modify storage.
REQ-026 All arithmetic SHALL be unsigned; the sweep counter never wraps because the FSM leaves CLEAR at DEPTH-1.

Reset
REQ-027 While rst=1 at an edge: state goes to CLEAR, counter=0, rd_a=rd_b=0, ready=0.
REQ-028 Asserting rst in RUN or mid-sweep SHALL restart the full sweep from address 0.
REQ-029 With sel_a=sel_b=00 and imm_sel=0 during reset, a and b SHALL read 0.
REQ-030 Array contents are not reset directly; the CLEAR sweep zeroes them.

Configuration
REQ-031 Macro REG_BANK_ZERO_REG_EN defined: register 0 SHALL read as 0 on both ports and writes to address 0 SHALL be discarded, including the write-first bypass when wa=0.
REQ-032 REG_BANK_ZERO_REG_EN undefined: register 0 SHALL behave as an ordinary register.

Verification
REQ-033 Defaults; pulse rst one cycle -> ready=0 for exactly 32 cycles, then 1; reads of all 32 addresses return 0x0000.
REQ-034 RUN; write 0xBEEF to address 7, next cycle ra_a=7, sel_a=00 -> a=0xBEEF one cycle later.
REQ-035 RUN; we=1, wa=3, wd=0x1234 with ra_b=3 in the same cycle -> b=0x1234 next cycle (write-first).
REQ-036 ans_ex=0x0001, ans_dm=0x0002, ans_wb=0x0003, imm=0x00FF; sweep sel_a/sel_b through 00..11 and toggle imm_sel -> a/b follow REQ-023/REQ-024 combinationally; imm_sel=1 forces b=0x00FF.
REQ-037 Assert rst at sweep count 10, then release -> ready stays 0 for a further 32 cycles; write at count 5 with we=1 is ignored.
REQ-038 With REG_BANK_ZERO_REG_EN defined, write 0xFFFF to address 0 and read it on both ports -> a=b=0x0000, including in the same-cycle bypass case.
